// File: rtl/biu_wb_bridge.sv
// CPU bus interface bridge: routes one region to a Wishbone classic master with
// retry/timeout handling, and everything else combinationally to the MIO port.
module biu_wb_bridge #(
  parameter logic [3:0]  WB_REGION = 4'h3,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [1:0]  cpu_size_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ready_o,
  output logic        cpu_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic        mio_we_o,
  output logic [31:0] mio_addr_o,
  output logic [31:0] mio_wdata_o,
  input  logic [31:0] mio_rdata_i,
  input  logic        mio_ready_i
);

  localparam logic [15:0] TmoLast  = 16'(TIMEOUT - 1);
  localparam logic [3:0]  RetryMax = 4'(MAX_RETRY);

  typedef enum logic [1:0] {StIdle, StActive, StBackoff, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] tmo_q, tmo_d;

  logic        wb_region;
  logic        misaligned;
  logic [3:0]  sel_calc;
  logic [31:0] dat_calc;

  assign wb_region = (cpu_addr_i[31:28] == WB_REGION);

  always_comb begin
    misaligned = 1'b0;
    sel_calc   = 4'b0000;
    dat_calc   = cpu_wdata_i;
    unique case (cpu_size_i)
      2'b00: begin
        sel_calc = 4'b0001 << cpu_addr_i[1:0];
        dat_calc = {4{cpu_wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned = cpu_addr_i[0];
        sel_calc   = 4'b0011 << cpu_addr_i[1:0];
        dat_calc   = {2{cpu_wdata_i[15:0]}};
      end
      2'b10: begin
        misaligned = |cpu_addr_i[1:0];
        sel_calc   = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req_i && wb_region) begin
          rdata_d = 32'h0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            adr_d   = {cpu_addr_i[31:2], 2'b00};
            we_d    = cpu_we_i;
            sel_d   = sel_calc;
            dat_d   = dat_calc;
            err_d   = 1'b0;
            retry_d = 4'h0;
            tmo_d   = 16'h0;
            state_d = StActive;
          end
        end
      end
      StActive: begin
        if (wb_ack_i) begin
          rdata_d = we_q ? 32'h0 : wb_dat_i;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (wb_err_i) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else if (wb_rty_i) begin
          if (retry_q < RetryMax) begin
            retry_d = retry_q + 4'h1;
            state_d = StBackoff;
          end else begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          tmo_d = tmo_q + 16'h1;
        end
      end
      StBackoff: begin
        tmo_d   = 16'h0;
        state_d = StActive;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      adr_q   <= 32'h0;
      dat_q   <= 32'h0;
      sel_q   <= 4'h0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      retry_q <= 4'h0;
      tmo_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
    end
  end

  // MIO path is combinational from IDLE, so it is gated by reset explicitly.
  always_comb begin
    cpu_rdata_o = 32'h0;
    cpu_ready_o = 1'b0;
    cpu_err_o   = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_sel_o    = 4'h0;
    wb_adr_o    = adr_q;
    wb_dat_o    = dat_q;
    mio_we_o    = 1'b0;
    mio_addr_o  = 32'h0;
    mio_wdata_o = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (rst && !wb_region) begin
          mio_we_o    = cpu_we_i & cpu_req_i;
          mio_addr_o  = cpu_addr_i;
          mio_wdata_o = cpu_wdata_i;
          cpu_rdata_o = mio_rdata_i;
          cpu_ready_o = mio_ready_i;
        end
      end
      StActive: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = we_q;
        wb_sel_o = sel_q;
      end
      StResp: begin
        cpu_ready_o = 1'b1;
        cpu_err_o   = err_q;
        cpu_rdata_o = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_biu_wb_bridge.sv
// Directed bench for biu_wb_bridge: Wishbone read/write, retry, timeout, MIO,
// misalignment and mid-transfer reset, with hand-computed expectations.
module tb_biu_wb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [1:0]  cpu_size_i = 2'b00;
  logic [31:0] cpu_addr_i = 32'h0;
  logic [31:0] cpu_wdata_i = 32'h0;
  logic [31:0] cpu_rdata_o;
  logic        cpu_ready_o;
  logic        cpu_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_rty_i = 1'b0;
  logic        mio_we_o;
  logic [31:0] mio_addr_o;
  logic [31:0] mio_wdata_o;
  logic [31:0] mio_rdata_i = 32'h0;
  logic        mio_ready_i = 1'b0;

  int passes = 0;
  int total  = 0;

  biu_wb_bridge #(
    .WB_REGION(4'h3),
    .TIMEOUT  (8),
    .MAX_RETRY(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req_i  (cpu_req_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_size_i (cpu_size_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o),
    .cpu_ready_o(cpu_ready_o),
    .cpu_err_o  (cpu_err_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i),
    .wb_rty_i   (wb_rty_i),
    .mio_we_o   (mio_we_o),
    .mio_addr_o (mio_addr_o),
    .mio_wdata_o(mio_wdata_o),
    .mio_rdata_i(mio_rdata_i),
    .mio_ready_i(mio_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wb_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata);
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_size_i  = size;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
  endtask

  initial begin
    int cnt;
    // Reset with mio_ready high: the combinational MIO path must stay masked.
    mio_ready_i = 1'b1;
    mio_rdata_i = 32'hCAFEF00D;
    #13;
    chk("rst_ready", cpu_ready_o, 0);
    chk("rst_rdata", cpu_rdata_o, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_sel", wb_sel_o, 0);
    chk("rst_mio_we", mio_we_o, 0);
    @(negedge clk);
    rst = 1'b1;
    mio_ready_i = 1'b0;
    step();

    // Word read, ack in the second ACTIVE cycle.
    wb_req(1'b0, 2'b10, 32'h3000_0010, 32'h0);
    settle();
    chk("rd_idle_cyc", wb_cyc_o, 0);
    step();
    chk("rd_a1_cyc", wb_cyc_o, 1);
    chk("rd_a1_stb", wb_stb_o, 1);
    chk("rd_sel", wb_sel_o, 4'hF);
    chk("rd_adr", wb_adr_o, 32'h3000_0010);
    chk("rd_we", wb_we_o, 0);
    chk("rd_a1_ready", cpu_ready_o, 0);
    step();
    chk("rd_a2_cyc", wb_cyc_o, 1);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hDEADBEEF;
    step();
    wb_ack_i = 1'b0;
    cpu_req_i = 1'b0;
    settle();
    chk("rd_ready", cpu_ready_o, 1);
    chk("rd_rdata", cpu_rdata_o, 32'hDEADBEEF);
    chk("rd_err", cpu_err_o, 0);
    chk("rd_resp_cyc", wb_cyc_o, 0);
    step();
    chk("rd_ready_1cyc", cpu_ready_o, 0);
    chk("rd_hold_adr", wb_adr_o, 32'h3000_0010);

    // Byte write to lane 3; req dropped mid-transfer must not abort it.
    wb_req(1'b1, 2'b00, 32'h3000_0003, 32'h0000_00A5);
    step();
    chk("bw_sel", wb_sel_o, 4'h8);
    chk("bw_dat", wb_dat_o, 32'hA5A5A5A5);
    chk("bw_we", wb_we_o, 1);
    chk("bw_adr", wb_adr_o, 32'h3000_0000);
    cpu_req_i = 1'b0;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h5555_5555;
    step();
    wb_ack_i = 1'b0;
    chk("bw_ready", cpu_ready_o, 1);
    chk("bw_err", cpu_err_o, 0);
    chk("bw_rdata", cpu_rdata_o, 0);
    step();

    // Half write at offset 2, terminated by wb_err.
    wb_req(1'b1, 2'b01, 32'h3000_0006, 32'hFFFF_1234);
    step();
    cpu_req_i = 1'b0;
    chk("hw_sel", wb_sel_o, 4'hC);
    chk("hw_dat", wb_dat_o, 32'h1234_1234);
    wb_err_i = 1'b1;
    step();
    wb_err_i = 1'b0;
    chk("hw_ready", cpu_ready_o, 1);
    chk("hw_err", cpu_err_o, 1);
    step();

    // Three retries then ack: three one-cycle cyc gaps, then success.
    wb_req(1'b0, 2'b10, 32'h3000_0020, 32'h0);
    step();
    cpu_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rty3_active_cyc", wb_cyc_o, 1);
      wb_rty_i = 1'b1;
      step();
      wb_rty_i = 1'b0;
      chk("rty3_gap_cyc", wb_cyc_o, 0);
      chk("rty3_gap_ready", cpu_ready_o, 0);
      step();
    end
    chk("rty3_final_cyc", wb_cyc_o, 1);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h1111_2222;
    step();
    wb_ack_i = 1'b0;
    chk("rty3_ready", cpu_ready_o, 1);
    chk("rty3_err", cpu_err_o, 0);
    chk("rty3_rdata", cpu_rdata_o, 32'h1111_2222);
    step();

    // Four retries exceed MAX_RETRY: error response.
    wb_req(1'b0, 2'b10, 32'h3000_0030, 32'h0);
    step();
    cpu_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_rty_i = 1'b1;
      step();
      wb_rty_i = 1'b0;
      step();
    end
    chk("rty4_cyc", wb_cyc_o, 1);
    wb_rty_i = 1'b1;
    step();
    wb_rty_i = 1'b0;
    chk("rty4_ready", cpu_ready_o, 1);
    chk("rty4_err", cpu_err_o, 1);
    chk("rty4_rdata", cpu_rdata_o, 0);
    chk("rty4_cyc_off", wb_cyc_o, 0);
    step();

    // Silent slave with TIMEOUT = 8: cyc stays high exactly 8 cycles.
    wb_req(1'b0, 2'b10, 32'h3000_0040, 32'h0);
    step();
    cpu_req_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && wb_cyc_o; i++) begin
      cnt++;
      step();
    end
    chk("tmo_cycles", cnt, 8);
    chk("tmo_ready", cpu_ready_o, 1);
    chk("tmo_err", cpu_err_o, 1);
    step();

    // MIO read and write are combinational from IDLE.
    cpu_req_i   = 1'b1;
    cpu_we_i    = 1'b0;
    cpu_size_i  = 2'b10;
    cpu_addr_i  = 32'h1000_0000;
    mio_ready_i = 1'b1;
    mio_rdata_i = 32'h1234_5678;
    settle();
    chk("mio_ready", cpu_ready_o, 1);
    chk("mio_rdata", cpu_rdata_o, 32'h1234_5678);
    chk("mio_cyc", wb_cyc_o, 0);
    chk("mio_err", cpu_err_o, 0);
    chk("mio_addr", mio_addr_o, 32'h1000_0000);
    chk("mio_rd_we", mio_we_o, 0);
    cpu_we_i    = 1'b1;
    cpu_wdata_i = 32'h0BAD_F00D;
    settle();
    chk("mio_wr_we", mio_we_o, 1);
    chk("mio_wdata", mio_wdata_o, 32'h0BAD_F00D);
    chk("mio_hold_adr", wb_adr_o, 32'h3000_0040);
    cpu_req_i   = 1'b0;
    mio_ready_i = 1'b0;
    step();

    // Misaligned half: no cyc, error response next cycle.
    wb_req(1'b0, 2'b01, 32'h3000_0001, 32'h0);
    settle();
    chk("mis_idle_cyc", wb_cyc_o, 0);
    step();
    cpu_req_i = 1'b0;
    chk("mis_cyc", wb_cyc_o, 0);
    chk("mis_ready", cpu_ready_o, 1);
    chk("mis_err", cpu_err_o, 1);
    chk("mis_adr_unlatched", wb_adr_o, 32'h3000_0040);
    step();

    // Reset mid-ACTIVE: cyc drops at once, no response, accepts right after release.
    wb_req(1'b0, 2'b10, 32'h3000_0050, 32'h0);
    step();
    cpu_req_i = 1'b0;
    chk("rmid_cyc_before", wb_cyc_o, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rmid_cyc_async", wb_cyc_o, 0);
    chk("rmid_ready_async", cpu_ready_o, 0);
    step();
    chk("rmid_ready_held", cpu_ready_o, 0);
    @(negedge clk);
    rst = 1'b1;
    wb_req(1'b0, 2'b10, 32'h3000_0060, 32'h0);
    step();
    cpu_req_i = 1'b0;
    chk("rmid_accept_cyc", wb_cyc_o, 1);
    chk("rmid_accept_adr", wb_adr_o, 32'h3000_0060);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h600D_600D;
    step();
    wb_ack_i = 1'b0;
    chk("rmid_ready", cpu_ready_o, 1);
    chk("rmid_rdata", cpu_rdata_o, 32'h600D_600D);
    step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
